// File: rtl/axi_lite_slave_resp_pkg.sv
// Shared types for the AXI4-Lite slave responder: response codes and FSM state encodings.
package axi_lite_slave_resp_pkg;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExokay = 2'b01,
        RespSlverr = 2'b10,
        RespDecerr = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        WIdle,
        WHaveA,
        WHaveD,
        WResp
    } wr_state_t;

    typedef enum logic {
        RIdle,
        RResp
    } rd_state_t;

    // Only OKAY and SLVERR are ever issued by this slave.
    function automatic resp_t decode_resp(logic hit);
        return hit ? RespOkay : RespSlverr;
    endfunction

endpackage

// File: rtl/axi_lite_slave_resp_if.sv
// AXI4-Lite AW/W/B/AR/R channel bundle with master and slave views.
interface axi_lite_slave_resp_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    import axi_lite_slave_resp_pkg::*;

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    resp_t                   bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    resp_t                   rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_slave_resp_regfile.sv
// Word array behind the responder: async clear, byte-strobed write, combinational read.
module axi_lite_slave_resp_regfile #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read sees the pre-edge contents, so a same-edge write is not visible yet.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi_lite_slave_resp.sv
// AXI4-Lite slave responder: independent write (AW/W/B) and read (AR/R) FSMs over a register array.
module axi_lite_slave_resp
    import axi_lite_slave_resp_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input logic                  clk,
    input logic                  rst,
    axi_lite_slave_resp_if.slave bus
);

    localparam int unsigned           STRB_W  = DATA_WIDTH / 8;
    localparam int unsigned           IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    // Unsigned wrap makes addresses below BASE_ADDR fall outside the window too.
    function automatic logic in_window(logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word;
        word = (addr - BASE_ADDR) >> 2;
        return word < DEPTH_A;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word;
        word = (addr - BASE_ADDR) >> 2;
        return IDX_W'(word);
    endfunction

    // Write path
    wr_state_t             wr_q, wr_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q;
    resp_t                 bresp_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;

    logic                  aw_hs, w_hs, commit, commit_hit;
    logic [ADDR_WIDTH-1:0] commit_addr;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [STRB_W-1:0]     commit_strb;

    assign aw_hs = bus.awvalid && awready_q;
    assign w_hs  = bus.wvalid && wready_q;

    // The half that arrived first comes from the holding register, the other from the bus.
    assign commit_addr = (wr_q == WHaveA) ? awaddr_q : bus.awaddr;
    assign commit_data = (wr_q == WHaveD) ? wdata_q : bus.wdata;
    assign commit_strb = (wr_q == WHaveD) ? wstrb_q : bus.wstrb;
    assign commit_hit  = in_window(commit_addr);

    always_comb begin
        wr_d   = wr_q;
        commit = 1'b0;
        unique case (wr_q)
            WIdle: begin
                if (aw_hs && w_hs) begin
                    wr_d   = WResp;
                    commit = 1'b1;
                end else if (aw_hs) begin
                    wr_d = WHaveA;
                end else if (w_hs) begin
                    wr_d = WHaveD;
                end
            end
            WHaveA: begin
                if (w_hs) begin
                    wr_d   = WResp;
                    commit = 1'b1;
                end
            end
            WHaveD: begin
                if (aw_hs) begin
                    wr_d   = WResp;
                    commit = 1'b1;
                end
            end
            WResp: begin
                if (bus.bready) begin
                    wr_d = WIdle;
                end
            end
            default: wr_d = WIdle;
        endcase
        awready_d = (wr_d == WIdle) || (wr_d == WHaveD);
        wready_d  = (wr_d == WIdle) || (wr_d == WHaveA);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q      <= WIdle;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RespOkay;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            wr_q      <= wr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= (wr_d == WResp);
            if (commit) begin
                bresp_q <= decode_resp(commit_hit);
            end
            if (aw_hs) begin
                awaddr_q <= bus.awaddr;
            end
            if (w_hs) begin
                wdata_q <= bus.wdata;
                wstrb_q <= bus.wstrb;
            end
        end
    end

    // Read path
    rd_state_t             rd_q, rd_d;
    logic                  arready_q;
    logic                  rvalid_q;
    resp_t                 rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  ar_hs, rd_hit;
    logic [31:0]           rf_rdata;
    logic [DATA_WIDTH-1:0] rd_word;

    assign ar_hs   = bus.arvalid && arready_q;
    assign rd_hit  = in_window(bus.araddr);
    assign rd_word = rd_hit ? rf_rdata : '0;

    always_comb begin
        rd_d = rd_q;
        unique case (rd_q)
            RIdle:   if (ar_hs) rd_d = RResp;
            RResp:   if (bus.rready) rd_d = RIdle;
            default: rd_d = RIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q      <= RIdle;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RespOkay;
            rdata_q   <= '0;
        end else begin
            rd_q      <= rd_d;
            arready_q <= (rd_d == RIdle);
            rvalid_q  <= (rd_d == RResp);
            if (ar_hs) begin
                rresp_q <= decode_resp(rd_hit);
                rdata_q <= rd_word;
            end
        end
    end

    axi_lite_slave_resp_regfile #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (commit && commit_hit),
        .waddr (word_idx(commit_addr)),
        .wdata (commit_data),
        .wstrb (commit_strb),
        .raddr (word_idx(bus.araddr)),
        .rdata (rf_rdata)
    );

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_axi_lite_slave_resp.sv
// Bench for axi_lite_slave_resp: transaction-level model checked every cycle plus directed literals.
module tb_axi_lite_slave_resp;
    import axi_lite_slave_resp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    axi_lite_slave_resp_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_lite_slave_resp #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (16),
        .BASE_ADDR  (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 16 words at 0x00..0x3F; one pending write and one pending read at a time.
    logic [31:0] m_mem [16];
    logic        m_awready, m_wready, m_arready, m_bvalid, m_rvalid;
    logic [1:0]  m_bresp, m_rresp;
    logic [31:0] m_rdata, m_addr, m_data;
    logic [3:0]  m_strb;
    logic        m_have_a, m_have_d, m_aw_hs, m_w_hs, m_ar_hs;

    function automatic logic hit(input logic [31:0] a);
        return a < 32'd64;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) m_mem[i] = '0;
            m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
            m_bresp = 0; m_rresp = 0; m_rdata = 0; m_have_a = 0; m_have_d = 0;
            m_addr = 0; m_data = 0; m_strb = 0;
        end else begin
            m_aw_hs = bus.awvalid && m_awready;
            m_w_hs  = bus.wvalid && m_wready;
            m_ar_hs = bus.arvalid && m_arready;
            // Read is evaluated before the write so a same-edge write is not seen.
            if (m_rvalid) begin
                if (bus.rready) begin m_rvalid = 0; m_arready = 1; end
            end else if (m_ar_hs) begin
                m_rvalid  = 1;
                m_arready = 0;
                m_rresp   = hit(bus.araddr) ? 2'b00 : 2'b10;
                m_rdata   = hit(bus.araddr) ? m_mem[bus.araddr[5:2]] : 32'h0;
            end else begin
                m_arready = 1;
            end
            if (m_bvalid) begin
                if (bus.bready) begin m_bvalid = 0; m_awready = 1; m_wready = 1; end
            end else begin
                if (m_aw_hs) begin m_have_a = 1; m_addr = bus.awaddr; end
                if (m_w_hs) begin m_have_d = 1; m_data = bus.wdata; m_strb = bus.wstrb; end
                if (m_have_a && m_have_d) begin
                    if (hit(m_addr))
                        for (int b = 0; b < 4; b++)
                            if (m_strb[b]) m_mem[m_addr[5:2]][8*b +: 8] = m_data[8*b +: 8];
                    m_bresp   = hit(m_addr) ? 2'b00 : 2'b10;
                    m_bvalid  = 1;
                    m_have_a  = 0;
                    m_have_d  = 0;
                    m_awready = 0;
                    m_wready  = 0;
                end else begin
                    m_awready = !m_have_a;
                    m_wready  = !m_have_d;
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #2;
        check("awready", bus.awready, m_awready);
        check("wready", bus.wready, m_wready);
        check("arready", bus.arready, m_arready);
        check("bvalid", bus.bvalid, m_bvalid);
        check("rvalid", bus.rvalid, m_rvalid);
        if (m_bvalid || !rst) check("bresp", bus.bresp, m_bresp);
        if (m_rvalid || !rst) begin
            check("rresp", bus.rresp, m_rresp);
            check("rdata", bus.rdata, m_rdata);
        end
    end

    task automatic idle();
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        bus.awaddr = 0; bus.wdata = 0; bus.wstrb = 0; bus.araddr = 0;
        bus.bready = 1; bus.rready = 1;
    endtask

    task automatic wr_same(input logic [31:0] a, d, input logic [3:0] s, input logic [1:0] r);
        bus.awaddr = a; bus.awvalid = 1; bus.wdata = d; bus.wstrb = s; bus.wvalid = 1;
        check("b_pre", bus.bvalid, 0);
        @(negedge clk);
        check("b_lat", bus.bvalid, 1);
        check("b_resp", bus.bresp, r);
        bus.awvalid = 0; bus.wvalid = 0;
        @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a, d, input logic [1:0] r);
        bus.araddr = a; bus.arvalid = 1;
        @(negedge clk);
        check("r_lat", bus.rvalid, 1);
        check("r_data", bus.rdata, d);
        check("r_resp", bus.rresp, r);
        bus.arvalid = 0;
        @(negedge clk);
    endtask

    initial begin
        idle();
        // Reset with random inputs
        repeat (4) begin
            @(negedge clk);
            bus.awvalid = 1'($urandom); bus.wvalid = 1'($urandom); bus.arvalid = 1'($urandom);
            bus.bready = 1'($urandom); bus.rready = 1'($urandom);
            bus.awaddr = $urandom; bus.wdata = $urandom; bus.araddr = $urandom;
            bus.wstrb = 4'($urandom);
            #1;
            check("rst_outs", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 0);
            check("rst_data", {bus.rdata[29:0], bus.rresp}, 0);
        end
        @(negedge clk);
        idle();
        rst = 1;
        #1 check("rel_ready0", {bus.awready, bus.wready, bus.arready}, 3'b000);
        @(negedge clk);
        check("rel_ready1", {bus.awready, bus.wready, bus.arready}, 3'b111);

        wr_same(32'h8, 32'hDEADBEEF, 4'hF, 2'b00);
        rd(32'h8, 32'hDEADBEEF, 2'b00);

        // Split write: W three cycles ahead of AW
        bus.wdata = 32'h11223344; bus.wstrb = 4'b0101; bus.wvalid = 1;
        @(negedge clk);
        bus.wvalid = 0;
        repeat (3) begin
            check("split_wready", bus.wready, 0);
            check("split_awready", bus.awready, 1);
            if (bus.awvalid == 0) bus.awaddr = 32'h4;
            @(negedge clk);
        end
        bus.awvalid = 1;
        @(negedge clk);
        check("split_b", {bus.bvalid, bus.bresp}, 3'b100);
        bus.awvalid = 0;
        @(negedge clk);
        rd(32'h4, 32'h00220044, 2'b00);

        // Out of window
        wr_same(32'h40, 32'h12345678, 4'hF, 2'b10);
        rd(32'h40, 32'h0, 2'b10);
        rd(32'h3C, 32'h0, 2'b00);
        rd(32'h0, 32'h0, 2'b00);

        // Backpressure on both response channels
        bus.bready = 0; bus.rready = 0;
        bus.awaddr = 32'hC; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
        bus.awvalid = 1; bus.wvalid = 1; bus.araddr = 32'h8; bus.arvalid = 1;
        @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        repeat (5) begin
            check("bp_b", {bus.bvalid, bus.bresp}, 3'b100);
            check("bp_r", {bus.rvalid, bus.rresp}, 3'b100);
            check("bp_rdata", bus.rdata, 32'hDEADBEEF);
            check("bp_ready", {bus.awready, bus.wready, bus.arready}, 3'b000);
            @(negedge clk);
        end
        bus.bready = 1; bus.rready = 1;
        @(negedge clk);
        check("bp_done", {bus.bvalid, bus.rvalid}, 2'b00);
        @(negedge clk);
        rd(32'hC, 32'hCAFEF00D, 2'b00);

        // Write commit and read capture on the same word in the same edge
        wr_same(32'h0, 32'hAAAAAAAA, 4'hF, 2'b00);
        bus.awaddr = 32'h0; bus.wdata = 32'h55555555; bus.wstrb = 4'hF;
        bus.awvalid = 1; bus.wvalid = 1; bus.araddr = 32'h0; bus.arvalid = 1;
        @(negedge clk);
        check("col_rdata", bus.rdata, 32'hAAAAAAAA);
        check("col_valid", {bus.bvalid, bus.rvalid}, 2'b11);
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        @(negedge clk);
        rd(32'h0, 32'h55555555, 2'b00);

        // Reset while only AW has been accepted
        bus.awaddr = 32'h10; bus.awvalid = 1;
        @(negedge clk);
        bus.awvalid = 0;
        check("hava_ready", {bus.awready, bus.wready}, 2'b01);
        rst = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        #1 check("rel2_ready0", {bus.awready, bus.wready, bus.arready}, 3'b000);
        @(negedge clk);
        check("rel2_ready1", {bus.awready, bus.wready, bus.arready}, 3'b111);
        repeat (3) begin
            check("rel2_nob", bus.bvalid, 0);
            @(negedge clk);
        end
        rd(32'h10, 32'h0, 2'b00);
        rd(32'h8, 32'h0, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
